// File: rtl/up_count_capture.sv
// Elapsed-tick measurement: Start clears and runs a saturating counter, Stop
// freezes the count into Captured and holds it until the consumer acknowledges.
module up_count_capture #(
    parameter int data_width = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Enable,
    input  logic                  Ack,
    output logic [data_width-1:0] count,
    output logic [data_width-1:0] Captured,
    output logic                  Valid,
    output logic                  Busy,
    output logic                  Overflow,
    output logic [1:0]            dbg_state
);

    // Handshake: Valid rises on the Stop edge and stays high until the first
    // edge with Ack=1; Captured is stable for the whole time Valid is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [data_width-1:0] COUNT_MAX = '1;

    state_t                state_q, state_d;
    logic [data_width-1:0] count_q, count_d;
    logic [data_width-1:0] captured_q, captured_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        captured_d = captured_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = RUN;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            RUN: begin
                // Stop captures the pre-increment value and beats Start/Enable.
                if (Stop) begin
                    state_d    = HOLD;
                    captured_d = count_q;
                end else if (Start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (Enable) begin
                    if (count_q == COUNT_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            captured_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            captured_q <= captured_d;
            overflow_q <= overflow_d;
        end
    end

    assign count     = count_q;
    assign Captured  = captured_q;
    assign Overflow  = overflow_q;
    assign Busy      = (state_q == RUN);
    assign Valid     = (state_q == HOLD);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_up_count_capture.sv
// Bench for up_count_capture: directed scenarios plus a randomized run, all
// checked against a rule-level model of the measurement.
module tb_up_count_capture;

    localparam int W = 4;
    localparam int MAX = 15;

    logic         CLK;
    logic         RST;
    logic         Start;
    logic         Stop;
    logic         Enable;
    logic         Ack;
    logic [W-1:0] count;
    logic [W-1:0] Captured;
    logic         Valid;
    logic         Busy;
    logic         Overflow;
    logic [1:0]   dbg_state;

    int checks;
    int failures;

    // Model: phase 0 = idle, 1 = measuring, 2 = result waiting for Ack.
    int m_phase;
    int m_count;
    int m_cap;
    int m_ovf;

    up_count_capture #(.data_width(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Enable(Enable), .Ack(Ack),
        .count(count), .Captured(Captured), .Valid(Valid), .Busy(Busy),
        .Overflow(Overflow), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_cap   = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic e, input logic a);
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_count = 0;
                m_ovf   = 0;
            end
        end else if (m_phase == 1) begin
            if (p) begin
                m_cap   = m_count;
                m_phase = 2;
            end else if (s) begin
                m_count = 0;
                m_ovf   = 0;
            end else if (e) begin
                if (m_count >= MAX) m_ovf = 1;
                m_count = (m_count + 1 > MAX) ? MAX : m_count + 1;
            end
        end else begin
            if (a) m_phase = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1ns after.
    task automatic cyc(input logic s, input logic p, input logic e, input logic a);
        Start = s; Stop = p; Enable = e; Ack = a;
        @(posedge CLK);
        model_step(s, p, e, a);
        #1;
        Start = 0; Stop = 0; Enable = 0; Ack = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 0; Stop = 0; Enable = 0; Ack = 0;
        model_reset();
        #1;
        checks++;
        if (count !== 0 || Captured !== 0 || Valid !== 0 || Busy !== 0 || Overflow !== 0) begin
            failures++;
            $display("FAIL reset_outputs got count=%0d cap=%0d v=%0b b=%0b o=%0b exp all 0",
                     count, Captured, Valid, Busy, Overflow);
        end
        @(negedge CLK);
        RST = 1'b0;
        // First edge after reset release must accept Start.
        cyc(1, 0, 0, 0);
        checks++;
        if (Busy !== 1'b1 || count !== 0) begin
            failures++;
            $display("FAIL reset_first_start got busy=%0b count=%0d exp busy=1 count=0", Busy, count);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        checks++;
        if (Captured !== 4'd5 || Valid !== 1'b1 || Busy !== 1'b0 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_capture got cap=%0d v=%0b b=%0b o=%0b exp cap=5 v=1 b=0 o=0",
                     Captured, Valid, Busy, Overflow);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (Valid !== 1'b0 || Captured !== 4'd5) begin
            failures++;
            $display("FAIL basic_ack got v=%0b cap=%0d exp v=0 cap=5", Valid, Captured);
        end
    endtask

    task automatic test_saturate();
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0, 1, 0);
            checks++;
            if (count !== ((i < MAX) ? i : MAX) || Overflow !== (i > MAX)) begin
                failures++;
                $display("FAIL saturate_tick%0d got count=%0d o=%0b exp count=%0d o=%0b",
                         i, count, Overflow, (i < MAX) ? i : MAX, (i > MAX));
            end
        end
        cyc(0, 1, 0, 0);
        checks++;
        if (Captured !== 4'd15 || Overflow !== 1'b1 || Valid !== 1'b1) begin
            failures++;
            $display("FAIL saturate_capture got cap=%0d o=%0b v=%0b exp cap=15 o=1 v=1",
                     Captured, Overflow, Valid);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_restart();
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);
        // Restart with Enable high: Enable must be ignored on this cycle.
        cyc(1, 0, 1, 0);
        checks++;
        if (count !== 0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear got count=%0d b=%0b exp count=0 b=1", count, Busy);
        end
        repeat (2) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        checks++;
        if (Captured !== 4'd2 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL restart_capture got cap=%0d o=%0b exp cap=2 o=0", Captured, Overflow);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_enable_toggle();
        logic [4:0] pat;
        pat = 5'b10101;
        cyc(1, 0, 0, 0);
        for (int i = 4; i >= 0; i--) cyc(0, 0, pat[i], 0);
        cyc(0, 1, 1, 0);
        checks++;
        if (Captured !== 4'd3 || count !== 4'd3) begin
            failures++;
            $display("FAIL toggle_capture got cap=%0d count=%0d exp cap=3 count=3", Captured, count);
        end
        // HOLD ignores Stop, Enable and Start while Ack is low.
        cyc(1, 1, 1, 0);
        checks++;
        if (Valid !== 1'b1 || count !== 4'd3 || Captured !== 4'd3) begin
            failures++;
            $display("FAIL hold_ignore got v=%0b count=%0d cap=%0d exp v=1 count=3 cap=3",
                     Valid, count, Captured);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_start_ack_hold();
        cyc(1, 0, 0, 0);
        repeat (7) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        checks++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || Captured !== 4'd7) begin
            failures++;
            $display("FAIL start_ack got v=%0b b=%0b cap=%0d exp v=0 b=0 cap=7", Valid, Busy, Captured);
        end
        cyc(1, 0, 0, 0);
        checks++;
        if (Busy !== 1'b1 || count !== 0 || Captured !== 4'd7) begin
            failures++;
            $display("FAIL start_after_ack got b=%0b count=%0d cap=%0d exp b=1 count=0 cap=7",
                     Busy, count, Captured);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_idle_ignore();
        cyc(0, 1, 1, 1);
        checks++;
        if (Busy !== 1'b0 || Valid !== 1'b0 || count !== m_count[W-1:0] || Captured !== m_cap[W-1:0]) begin
            failures++;
            $display("FAIL idle_ignore got b=%0b v=%0b count=%0d cap=%0d exp b=0 v=0 count=%0d cap=%0d",
                     Busy, Valid, count, Captured, m_count, m_cap);
        end
        cyc(1, 1, 1, 0);
        checks++;
        if (Busy !== 1'b1 || Valid !== 1'b0 || count !== 0) begin
            failures++;
            $display("FAIL idle_start_stop got b=%0b v=%0b count=%0d exp b=1 v=0 count=0", Busy, Valid, count);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0);
        repeat (9) cyc(0, 0, 1, 0);
        checks++;
        if (count !== 4'd9) begin
            failures++;
            $display("FAIL areset_pre got count=%0d exp 9", count);
        end
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (count !== 0 || Captured !== 0 || Valid !== 0 || Busy !== 0 || Overflow !== 0) begin
            failures++;
            $display("FAIL areset_outputs got count=%0d cap=%0d v=%0b b=%0b o=%0b exp all 0",
                     count, Captured, Valid, Busy, Overflow);
        end
        @(negedge CLK);
        RST = 1'b0;
        cyc(0, 1, 1, 0);
        checks++;
        if (Captured !== 0 || Valid !== 0) begin
            failures++;
            $display("FAIL areset_no_capture got cap=%0d v=%0b exp cap=0 v=0", Captured, Valid);
        end
    endtask

    task automatic test_random();
        logic s, p, e, a;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 17) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 2) == 0);
            cyc(s, p, e, a);
            checks++;
            if (count !== m_count[W-1:0] || Captured !== m_cap[W-1:0] || Overflow !== (m_ovf != 0)
                || Busy !== (m_phase == 1) || Valid !== (m_phase == 2)) begin
                failures++;
                $display("FAIL random_cycle%0d got count=%0d cap=%0d o=%0b b=%0b v=%0b exp count=%0d cap=%0d o=%0d b=%0b v=%0b",
                         i, count, Captured, Overflow, Busy, Valid,
                         m_count, m_cap, m_ovf, (m_phase == 1), (m_phase == 2));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_saturate();
        test_restart();
        test_enable_toggle();
        test_start_ack_hold();
        test_idle_ignore();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_count_capture.md
UP_COUNT_CAPTURE -- requirements
Module: up_count_capture

Interface
REQ-001 SHALL have parameter data_width, default 4, setting the width of the counter and the captured value.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, begin or restart a measurement.
REQ-005 SHALL have port Stop, input, 1, end the measurement and capture the count.
REQ-006 SHALL have port Enable, input, 1, count tick, qualifying increments while running.
REQ-007 SHALL have port Ack, input, 1, consumer acknowledge of the captured value.
REQ-008 SHALL have port count, output, data_width, live elapsed-tick count.
REQ-009 SHALL have port Captured, output, data_width, frozen measurement; directly usable as a down-counter Preset.
REQ-010 SHALL have port Valid, output, 1, high while Captured holds an unacknowledged measurement; usable as a down-counter Load.
REQ-011 SHALL have port Busy, output, 1, high while in RUN.
REQ-012 SHALL have port Overflow, output, 1, sticky flag meaning the count saturated during the current or last measurement.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HOLD; Busy = (state == RUN), Valid = (state == HOLD), both registered-state decodes.
REQ-014 IDLE: Start=1 -> RUN, count <= 0, Overflow <= 0; otherwise the state, count and Overflow hold.
REQ-015 IDLE: Stop, Enable and Ack SHALL be ignored; Start+Stop in the same cycle -> Start wins, enter RUN.
REQ-016 RUN, Stop=0, Start=0, Enable=1, count != 2^data_width-1 -> count <= count+1.
REQ-017 RUN, Enable=1, count == 2^data_width-1 -> count holds (saturates, no wrap), Overflow <= 1.
REQ-018 RUN, Enable=0 -> count holds.
REQ-019 RUN, Stop=1 -> Captured <= current count (pre-increment value), count not incremented that cycle, state -> HOLD; Stop has priority over Start and Enable.
REQ-020 RUN, Start=1, Stop=0 -> restart: count <= 0, Overflow <= 0, remain in RUN, Enable ignored that cycle.
REQ-021 HOLD: Captured, count and Overflow SHALL hold; Ack=1 -> IDLE next cycle (Valid low one cycle after the Ack edge).
REQ-022 HOLD: Start SHALL be ignored, including when asserted together with Ack; a new measurement requires Start in IDLE.
REQ-023 HOLD: Stop and Enable SHALL be ignored.
REQ-024 Captured SHALL change only on the RUN->HOLD transition and on reset.
REQ-025 Latency: Start edge -> Busy=1 after the same edge; Stop edge -> Valid=1 and Captured updated after the same edge.

Reset
REQ-026 RST=1 SHALL immediately, regardless of CLK, force state IDLE, count=0, Captured=0, Overflow=0, Valid=0, Busy=0.
REQ-027 Reset asserted mid-RUN or mid-HOLD SHALL discard the measurement; no capture occurs.
REQ-028 After RST deasserts, the block SHALL accept Start on the first rising CLK edge.

Verification (data_width=4)
REQ-029 Start 1 cycle, Enable high 5 cycles, Stop -> Captured=5, Valid=1, Busy=0, Overflow=0; Ack -> Valid=0 next cycle.
REQ-030 Start, Enable high 20 cycles, Stop -> count=15 from the 15th tick onward, Overflow=1, Captured=15.
REQ-031 Start, Enable high 3 cycles, Start again, Enable high 2 cycles, Stop -> Captured=2, Overflow=0.
REQ-032 Enable toggling 1,0,1,0,1 in RUN, then Stop with Enable=1 in the same cycle -> Captured=3, count=3.
REQ-033 In HOLD with Captured=7, assert Start+Ack together -> IDLE, Busy=0, Captured stays 7; Start next cycle -> RUN, count=0.
REQ-034 Assert RST asynchronously mid-RUN at count=9 -> all outputs 0 before the next CLK edge; Captured stays 0.
